mem_stage: RTL
==============

# mem_stage

Memory-access pipeline stage of the five-stage RISC-V core. It consumes the EX/MEM pipeline register outputs and resolves branches. It runs loads and stores against the data memory over a req/ready handshake, stalling the upstream pipeline while an access is outstanding. It drives the registered MEM/WB outputs into writeback.

## Interface
Parameters:
- DATA_W, 32, datapath and address width
- TIMEOUT_CYCLES, 255, max ACCESS cycles waiting for dmem_ready before abort; range 1..255

Ports:
- One clock `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX/MEM holds a live instruction
- alu_result  in  DATA_W  ALU result / memory address
- rdata2  in  DATA_W  store data
- branch_target  in  DATA_W  branch destination PC
- rd  in  5  destination register
- en_write_reg  in  1  regfile write enable
- alu_zero  in  1  ALU result zero
- alu_pos  in  1  ALU result positive; passed to wb_alu_pos, not otherwise used
- branch  in  1  branch instruction
- en_mem_read  in  1  load
- en_mem_write  in  1  store
- write_source  in  1  1 = memory data, 0 = alu_result to writeback
- pc_src  out  1  branch taken
- pc_branch  out  DATA_W  = branch_target
- mem_stall  out  1  hold IF..EX/MEM
- dmem_req  out  1  memory request, held until ready
- dmem_we  out  1  1 = store
- dmem_addr  out  DATA_W  access address
- dmem_wdata  out  DATA_W  store data
- dmem_ready  in  1  memory accepts/completes this cycle
- dmem_rdata  in  DATA_W  load data, valid with dmem_ready
- wb_valid  out  1  MEM/WB holds a live instruction
- wb_rd  out  5
- wb_en_write_reg  out  1
- wb_alu_pos  out  1
- wb_data  out  DATA_W  writeback value
- bus_error  out  1  sticky: an access timed out

## Operation
- FSM states: IDLE, ACCESS.
- A memory op is `in_valid & (en_mem_read | en_mem_write)`; if both are set, treat it as a read.
- IDLE, non-memory op:
  - MEM/WB loads at the next edge.
  - wb_data = alu_result.
  - wb_en_write_reg = en_write_reg.
- IDLE, memory op:
  - Capture addr, wdata, we, rd, write enable, write_source and alu_pos.
  - Go to ACCESS.
  - Load a wb bubble (wb_valid=0).
  - mem_stall=1 this cycle.
- ACCESS:
  - dmem_req=1 and the registered dmem_addr/dmem_wdata/dmem_we are stable.
  - mem_stall=1 unless dmem_ready.
  - Wait counter increments each cycle without ready.
- ACCESS with dmem_ready:
  - MEM/WB loads at the edge; wb_data = write_source ? dmem_rdata : captured alu_result.
  - Return to IDLE and clear the counter.
- ACCESS timeout (counter reaches TIMEOUT_CYCLES-1 without ready):
  - Drop req, set bus_error.
  - Write back with wb_en_write_reg=0 and wb_data=0.
  - Return to IDLE.
- Inputs during ACCESS are ignored; they are held upstream by the stall.
- Branch: pc_src = in_valid & branch & alu_zero & (state==IDLE), combinational. Branch ops never stall.
- bus_error clears only on rst.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0.
  - wb_valid 0, wb_rd 0, wb_en_write_reg 0, wb_alu_pos 0, wb_data 0.
  - bus_error 0.
  - pc_src and mem_stall 0 while rst is asserted.
- Reset mid-ACCESS: dmem_req is 0 in the cycle after the rst edge. No writeback occurs.
- Non-memory latency: wb_* valid 1 cycle after in_valid is sampled.
- Memory latency: 2 + N cycles, where N is the number of ACCESS cycles before ready (N=0 when ready arrives in the first ACCESS cycle).
- mem_stall deasserts in the dmem_ready cycle, so upstream advances at the same edge that MEM/WB captures.
- dmem_ready outside ACCESS is ignored.
- Ready and timeout in the same cycle: ready wins, no error.
- Back-to-back memory ops: the second is seen in IDLE the cycle after completion, giving one IDLE cycle between requests.

## Structure
- Shared package `mem_pkg`:
  - state enum (IDLE, ACCESS)
  - DATA_W default
  - timeout counter width (8 bits)
- Sub-module `mem_wb_reg`: the MEM/WB register, with load/bubble inputs and reset to zero. The FSM, counter and bus capture stay in mem_stage.

## Test plan
- ALU op: in_valid, rd=5, alu_result=0x1234, en_write_reg=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, mem_stall never 1.
- Load, ready after 3 wait cycles: addr 0x40, rdata 0xDEADBEEF, write_source=1 -> dmem_req high 4 cycles, dmem_addr=0x40, mem_stall high 4 cycles, then wb_data=0xDEADBEEF, wb_valid=1.
- Store, ready in the first ACCESS cycle: addr 0x80, rdata2 0xA5A5A5A5 -> dmem_we=1, dmem_wdata=0xA5A5A5A5 for 1 cycle, writeback 2 cycles after issue.
- Timeout with TIMEOUT_CYCLES=4, ready never asserted -> req drops after 4 cycles, bus_error=1 and stays high, wb_en_write_reg=0, next instruction proceeds.
- Branch with alu_zero=1, branch_target 0x200 -> pc_src=1, pc_branch=0x200 the same cycle. With alu_zero=0 -> pc_src=0.
- rst asserted during the second ACCESS cycle -> dmem_req=0, wb_valid=0, state IDLE the next cycle; a fresh load then completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 8;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures the writeback bundle on load, clears it on bubble.
module mem_wb_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic [4:0]        d_rd,
    input  logic              d_en_write_reg,
    input  logic              d_alu_pos,
    input  logic [DATA_W-1:0] d_data,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_en_write_reg,
    output logic              wb_alu_pos,
    output logic [DATA_W-1:0] wb_data
);

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            wb_valid        <= 1'b0;
            wb_rd           <= '0;
            wb_en_write_reg <= 1'b0;
            wb_alu_pos      <= 1'b0;
            wb_data         <= '0;
        end else if (load) begin
            wb_valid        <= 1'b1;
            wb_rd           <= d_rd;
            wb_en_write_reg <= d_en_write_reg;
            wb_alu_pos      <= d_alu_pos;
            wb_data         <= d_data;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch resolution, data-memory access FSM with timeout, MEM/WB register.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [DATA_W-1:0] branch_target,
    input  logic [4:0]        rd,
    input  logic              en_write_reg,
    input  logic              alu_zero,
    input  logic              alu_pos,
    input  logic              branch,
    input  logic              en_mem_read,
    input  logic              en_mem_write,
    input  logic              write_source,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_branch,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_en_write_reg,
    output logic              wb_alu_pos,
    output logic [DATA_W-1:0] wb_data,
    output logic              bus_error
);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [4:0]        cap_rd_reg;
    logic              cap_wen_reg;
    logic              cap_ws_reg;
    logic              cap_pos_reg;

    logic mem_op;
    logic in_access;
    logic access_done;
    logic timeout_hit;

    logic              wb_load;
    logic              wb_bubble;
    logic [4:0]        wb_d_rd;
    logic              wb_d_wen;
    logic              wb_d_pos;
    logic [DATA_W-1:0] wb_d_data;

    assign mem_op      = in_valid & (en_mem_read | en_mem_write);
    assign in_access   = (state_reg == ACCESS);
    assign access_done = in_access & dmem_ready;
    assign timeout_hit = in_access & ~dmem_ready & (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    assign dmem_req  = in_access;
    assign pc_branch = branch_target;
    assign pc_src    = ~rst & in_valid & branch & alu_zero & ~in_access;
    // Stall also drops on the abort cycle so the upstream op retires instead of reissuing.
    assign mem_stall = ~rst & (in_access ? ~(dmem_ready | timeout_hit) : mem_op);

    always_comb begin
        wb_load   = 1'b0;
        wb_bubble = 1'b0;
        wb_d_rd   = rd;
        wb_d_wen  = en_write_reg;
        wb_d_pos  = alu_pos;
        wb_d_data = alu_result;
        if (!in_access) begin
            if (in_valid && !mem_op) begin
                wb_load = 1'b1;
            end else begin
                wb_bubble = 1'b1;
            end
        end else begin
            wb_d_rd  = cap_rd_reg;
            wb_d_pos = cap_pos_reg;
            if (access_done) begin
                wb_load   = 1'b1;
                wb_d_wen  = cap_wen_reg;
                wb_d_data = cap_ws_reg ? dmem_rdata : dmem_addr;
            end else if (timeout_hit) begin
                wb_load   = 1'b1;
                wb_d_wen  = 1'b0;
                wb_d_data = '0;
            end else begin
                wb_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            cap_rd_reg  <= '0;
            cap_wen_reg <= 1'b0;
            cap_ws_reg  <= 1'b0;
            cap_pos_reg <= 1'b0;
            bus_error   <= 1'b0;
        end else if (!in_access) begin
            if (mem_op) begin
                state_reg   <= ACCESS;
                cnt_reg     <= '0;
                dmem_we     <= en_mem_write & ~en_mem_read;
                dmem_addr   <= alu_result;
                dmem_wdata  <= rdata2;
                cap_rd_reg  <= rd;
                cap_wen_reg <= en_write_reg;
                cap_ws_reg  <= write_source;
                cap_pos_reg <= alu_pos;
            end
        end else if (access_done || timeout_hit) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            if (timeout_hit) begin
                bus_error <= 1'b1;
            end
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    mem_wb_reg #(
        .DATA_W(DATA_W)
    ) u_mem_wb_reg (
        .clk            (clk),
        .rst            (rst),
        .load           (wb_load),
        .bubble         (wb_bubble),
        .d_rd           (wb_d_rd),
        .d_en_write_reg (wb_d_wen),
        .d_alu_pos      (wb_d_pos),
        .d_data         (wb_d_data),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_en_write_reg(wb_en_write_reg),
        .wb_alu_pos     (wb_alu_pos),
        .wb_data        (wb_data)
    );

endmodule
